// File: rtl/right_shifter_if.sv
// Data/amount/result bundle for the rotate-right shifter.
// The master drives a and amt; the slave returns the registered rotate in y.
interface right_shifter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
);
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] y;

  modport master (output a, output amt, input y);
  modport slave  (input a, input amt, output y);
endinterface

// File: rtl/right_shifter.sv
// Rotate-right barrel shifter: log2(WIDTH) cascaded 2:1 mux stages feeding one output register.
// Bits leaving the LSB re-enter at the MSB; y updates every cycle with no enable.
module right_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input logic            clk,
  input logic            rst_n,
  right_shifter_if.slave sh
);

  logic [WIDTH-1:0] w_stage [AMT_W+1];
  logic [WIDTH-1:0] r_y;

  assign w_stage[0] = sh.a;

  // Stage k rotates right by 2^k when amt[k] is set.
  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int unsigned Sh = 1 << k;
    assign w_stage[k+1] = sh.amt[k] ? {w_stage[k][Sh-1:0], w_stage[k][WIDTH-1:Sh]}
                                    : w_stage[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y <= '0;
    end else begin
      r_y <= w_stage[AMT_W];
    end
  end

  assign sh.y = r_y;

endmodule

// File: tb/tb_right_shifter.sv
// Randomized bench for right_shifter with a rotate reference model and literal spot checks.
module tb_right_shifter;
  localparam int unsigned W = 8;
  localparam int unsigned A = 3;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] m_y;
  int           n_chk;
  int           n_fail;
  bit           chk_en;

  right_shifter_if #(.WIDTH(W), .AMT_W(A)) sh ();

  right_shifter #(.WIDTH(W), .AMT_W(A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sh    (sh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate right as the low half of the doubled word shifted right.
  function automatic logic [W-1:0] rot(input logic [W-1:0] v, input int unsigned s);
    logic [2*W-1:0] d;
    d = {v, v} >> s;
    return d[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: one-cycle registered rotate, cleared asynchronously by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_y <= '0;
    else        m_y <= rot(sh.a, int'(sh.amt));
  end

  always @(negedge clk) begin
    if (chk_en) check("model", sh.y, m_y);
  end

  task automatic cyc(input logic [W-1:0] a, input logic [A-1:0] amt);
    sh.a   = a;
    sh.amt = amt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] sweep [8];
    n_chk  = 0;
    n_fail = 0;
    chk_en = 1'b0;
    sweep  = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

    rst_n  = 1'b1;
    sh.a   = 8'hFF;
    sh.amt = 3'd3;
    #1 rst_n = 1'b0;
    #1 check("reset_async", sh.y, 8'h00);
    chk_en = 1'b1;
    @(posedge clk);
    #1 check("reset_hold", sh.y, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release", sh.y, 8'hFF);

    cyc(8'h06, 3'd1);
    check("basic_amt1", sh.y, 8'h03);
    cyc(8'h06, 3'd2);
    check("basic_amt2", sh.y, 8'h81);

    for (int i = 0; i < 8; i++) begin
      cyc(8'h01, 3'(i));
      check($sformatf("sweep_amt%0d", i), sh.y, sweep[i]);
    end

    cyc(8'hA5, 3'd4);
    check("pattern_a5", sh.y, 8'h5A);
    cyc(8'hB4, 3'd7);
    check("pattern_b4", sh.y, 8'h69);
    cyc(8'h00, 3'd5);
    check("all_zero", sh.y, 8'h00);
    cyc(8'hFF, 3'd6);
    check("all_ones", sh.y, 8'hFF);
    cyc(8'h3C, 3'd0);
    check("amt_zero", sh.y, 8'h3C);

    for (int i = 0; i < 300; i++) begin
      cyc(8'($urandom), 3'($urandom_range(7)));
      if ((i % 60) == 37) begin
        rst_n = 1'b0;
        #1 check("reset_mid", sh.y, 8'h00);
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
